// File: rtl/dot_matrix_scanner.sv
// Row-scan driver for the LED dot-matrix panel: digit glyph ROM, scan divider, frame-aligned glyph latch.
// Optional column scrolling is compiled in with `define DM_SCROLL_EN.
module dot_matrix_scanner #(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int SCAN_DIV       = 1000,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int SCROLL_FRAMES  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              glyph,
    input  logic                    blank,
    output logic [$clog2(ROWS)-1:0] row_bin,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         col,
    output logic                    frame_done
);
    localparam int RW = $clog2(ROWS);
    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]   div_cnt;
    logic [3:0]      glyph_q;
    logic            tick;
    logic            wrap;
    logic [RW-1:0]   row_nxt;
    logic [COLS-1:0] pat;
    logic [COLS-1:0] col_nxt;

    // Stroke set packed as {a,b,c,d,e,f,g}; codes above 9 light nothing.
    function automatic logic [6:0] glyph_strokes(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1111110;
            4'd1:    return 7'b0110000;
            4'd2:    return 7'b1101101;
            4'd3:    return 7'b1111001;
            4'd4:    return 7'b0110011;
            4'd5:    return 7'b1011011;
            4'd6:    return 7'b1011111;
            4'd7:    return 7'b1110000;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [COLS-1:0] rom_row(input logic [3:0] d, input logic [RW-1:0] r);
        logic [6:0]      s;
        logic [COLS-1:0] p;
        int              ri;
        s  = glyph_strokes(d);
        ri = int'(r);
        p  = '0;
        if ((s[6] && ri == 1) || (s[0] && ri == 7) || (s[3] && ri == 13))
            p[11:4] = '1;
        if ((s[1] && ri >= 1 && ri <= 7) || (s[2] && ri >= 7 && ri <= 13))
            p[11] = 1'b1;
        if ((s[5] && ri >= 1 && ri <= 7) || (s[4] && ri >= 7 && ri <= 13))
            p[4] = 1'b1;
        return p;
    endfunction

    function automatic logic [ROWS-1:0] row_drive(input logic [RW-1:0] r);
        logic [ROWS-1:0] oh;
        oh    = '0;
        oh[r] = 1'b1;
        return (ROW_ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    assign tick = (div_cnt == DW'(SCAN_DIV - 1));
    assign wrap = tick && (row_bin == RW'(ROWS - 1));

    // row, col and row_bin all load from row_nxt so they never disagree.
    always_comb begin
        row_nxt = row_bin;
        if (wrap)
            row_nxt = '0;
        else if (tick)
            row_nxt = row_bin + RW'(1);
    end

    assign pat = rom_row(glyph_q, row_nxt);

`ifdef DM_SCROLL_EN
    localparam int OW = $clog2(COLS);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [OW-1:0]     offset;
    logic [FW-1:0]     frame_cnt;
    logic [2*COLS-1:0] pat_rot;

    // Offset moves only on the wrap edge, when the loaded row is always empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset    <= '0;
            frame_cnt <= '0;
        end else if (wrap) begin
            if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                frame_cnt <= '0;
                offset    <= (offset == OW'(COLS - 1)) ? '0 : offset + OW'(1);
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    assign pat_rot = {pat, pat} << offset;
    assign col_nxt = blank ? '0 : pat_rot[2*COLS-1:COLS];
`else
    assign col_nxt = blank ? '0 : pat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            row_bin    <= '0;
            row        <= row_drive('0);
            col        <= '0;
            frame_done <= 1'b0;
            glyph_q    <= 4'd15;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + DW'(1);
            row_bin    <= row_nxt;
            row        <= row_drive(row_nxt);
            col        <= col_nxt;
            frame_done <= wrap;
            if (wrap)
                glyph_q <= glyph;
        end
    end
endmodule
